// File: rtl/bh1750_pkg.sv
// Shared BH1750 target definitions: opcodes, FSM states, default bus address.
// Latency: n/a. Backpressure: n/a.
`timescale 1ns/1ps
package bh1750_pkg;

    localparam logic [6:0] DEFAULT_ADDR7 = 7'h23;

    localparam logic [7:0] OP_PDOWN = 8'h00;
    localparam logic [7:0] OP_PON   = 8'h01;
    localparam logic [7:0] OP_RESET = 8'h07;
    localparam logic [7:0] OP_CH    = 8'h10;
    localparam logic [7:0] OP_CH2   = 8'h11;
    localparam logic [7:0] OP_CL    = 8'h13;
    localparam logic [7:0] OP_OH    = 8'h20;
    localparam logic [7:0] OP_OH2   = 8'h21;
    localparam logic [7:0] OP_OL    = 8'h23;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        CMD,
        CMD_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } state_t;

    function automatic logic is_one_time(input logic [7:0] op);
        return (op == OP_OH) || (op == OP_OH2) || (op == OP_OL);
    endfunction

    function automatic logic is_meas_op(input logic [7:0] op);
        return (op == OP_CH) || (op == OP_CH2) || (op == OP_CL) || is_one_time(op);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C input conditioning: 2-flop synchronizers, SCL edges, START/STOP detection.
// Latency: 3 clk from bus edge to event pulse. Backpressure: none, pulses are one cycle.
// sda_s is registered alongside the events so it is the bus level at the SCL rise.
`timescale 1ns/1ps
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            sda_s     <= 1'b1;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[0], scl};
            sda_sync  <= {sda_sync[0], sda};
            scl_d     <= scl_sync[1];
            sda_d     <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_d;
            scl_fall  <= ~scl_sync[1] & scl_d;
            sda_s     <= sda_sync[1];
            start_det <= scl_sync[1] & scl_d & ~sda_sync[1] & sda_d;
            stop_det  <= scl_sync[1] & scl_d & sda_sync[1] & ~sda_d;
        end
    end

endmodule

// File: rtl/bh1750_i2c_target.sv
// BH1750 ambient-light sensor emulation as an I2C target; BH1750_TGT_MEAS_DELAY_EN models conversion time.
// Latency: SDA moves 1 clk after a detected SCL fall (4 clk after the bus edge).
// Backpressure: never stretches SCL; unknown addresses/opcodes are NACKed.
`timescale 1ns/1ps
module bh1750_i2c_target
    import bh1750_pkg::*;
#(
    parameter logic [6:0] ADDR7       = DEFAULT_ADDR7,
    parameter int         MEAS_CYCLES = 6_000_000
) (
    input  logic        sys_clk,
    input  logic        _rst,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] lux_in,
    output logic        powered,
    output logic [7:0]  mode,
    output logic        busy,
    output logic        cmd_stb
);

    logic        scl_rise;
    logic        scl_fall;
    logic        sda_s;
    logic        start_det;
    logic        stop_det;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic [15:0] data_reg;
    logic        sda_oe;
    logic        rw;
    logic        cmd_ack;
    logic        m_ack;
    logic [7:0]  rx_byte;
    logic        op_ok;
    logic        load_now;

    i2c_bus_sync u_sync (
        .clk       (sys_clk),
        .rst_n     (_rst),
        .scl       (SCL),
        .sda       (SDA),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Reset gates the driver directly so the bus is freed in the reset cycle itself.
    assign SDA = (sda_oe && _rst) ? 1'b0 : 1'bz;

    assign rx_byte = {shift_reg[6:0], sda_s};
    assign op_ok   = (rx_byte == OP_PDOWN) || (rx_byte == OP_PON) ||
                     ((rx_byte == OP_RESET) && powered) || is_meas_op(rx_byte);

`ifdef BH1750_TGT_MEAS_DELAY_EN
    localparam logic [22:0] MEAS_LAST = 23'(MEAS_CYCLES - 1);

    logic [22:0] meas_cnt;
    logic        meas_start;

    assign meas_start = (state == CMD) && scl_rise && (bit_cnt == 4'd7) && is_meas_op(rx_byte);
    assign load_now   = powered && (mode != 8'h00) && (meas_cnt == MEAS_LAST);

    always_ff @(posedge sys_clk) begin
        if (!_rst) begin
            meas_cnt <= '0;
        end else if (meas_start || !powered || (mode == 8'h00) || (meas_cnt == MEAS_LAST)) begin
            meas_cnt <= '0;
        end else begin
            meas_cnt <= meas_cnt + 23'd1;
        end
    end
`else
    assign load_now = powered && (mode != 8'h00);
`endif

    always_ff @(posedge sys_clk) begin
        if (!_rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            cmd_ack   <= 1'b0;
            m_ack     <= 1'b0;
            powered   <= 1'b0;
            mode      <= 8'h00;
            busy      <= 1'b0;
            cmd_stb   <= 1'b0;
        end else begin
            cmd_stb <= 1'b0;

            if (load_now) begin
                data_reg <= lux_in;
                if (is_one_time(mode)) begin
                    mode    <= 8'h00;
                    powered <= 1'b0;
                end
            end

            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_reg <= {shift_reg[14:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift_reg[7:1] == ADDR7) begin
                                state  <= ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shift_reg[0];
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shift_reg <= data_reg;
                                sda_oe    <= ~data_reg[15];
                                state     <= TX_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= CMD;
                            end
                        end
                    end
                    CMD: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_reg <= {shift_reg[14:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                cmd_ack <= op_ok;
                                cmd_stb <= op_ok;
                                if (rx_byte == OP_PDOWN) begin
                                    powered <= 1'b0;
                                end else if (rx_byte == OP_PON) begin
                                    powered <= 1'b1;
                                end else if (rx_byte == OP_RESET && powered) begin
                                    data_reg <= '0;
                                end else if (is_meas_op(rx_byte)) begin
                                    mode <= rx_byte;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= cmd_ack;
                            state  <= CMD_ACK;
                        end
                    end
                    CMD_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WAIT_STOP;
                        end
                    end
                    TX_BYTE: begin
                        // shift_reg[15] is always the bit on the wire; 1s fill in for the 0xFF tail.
                        if (scl_rise && bit_cnt < 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= TX_ACK;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            shift_reg <= {shift_reg[14:0], 1'b1};
                            sda_oe    <= ~shift_reg[14];
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            m_ack <= ~sda_s;
                        end else if (scl_fall) begin
                            if (m_ack) begin
                                shift_reg <= {shift_reg[14:0], 1'b1};
                                sda_oe    <= ~shift_reg[14];
                                bit_cnt   <= '0;
                                state     <= TX_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
